ttt_move_ctrl: RTL and testbench

Turn-sequencing controller for the 3x3 tic-tac-toe board, sitting directly upstream of the position decoder. It accepts player move requests over a valid/ready handshake and rejects out-of-range or occupied cells. It alternates X and O and emits the one-cycle position/enable pair that drives the decoder and board write. It also tracks move count and game-over (win from the external win checker, or draw after 9 moves).

---
 rtl/ttt_pkg.sv | 29 ++
 rtl/ttt_turn_timer.sv | 42 ++++
 rtl/ttt_move_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ttt_move_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and constants for the tic-tac-toe move controller
// Contents: FSM state enum, player encodings, winner codes, board geometry
// defaults and the winner-code helper used by ttt_move_ctrl.
package ttt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int NUM_CELLS_DEFAULT = 9;
    localparam int POS_W             = 4;

    // Winner code credited to the player who made the last committed move.
    function automatic logic [1:0] winner_code(input logic last_mover);
        return (last_mover == PLAYER_O) ? WIN_O : WIN_X;
    endfunction

endpackage

// File: rtl/ttt_turn_timer.sv
// rtl/ttt_turn_timer.sv - idle-turn forfeit counter
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   run         count this cycle (controller idle, no new_game)
//   clear       force the count back to zero (accept or new_game)
//   expire      combinational: this edge ends the turn (count at TIMEOUT_CYCLES-1)
module ttt_turn_timer #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            // Wrap on expiry so the next turn gets a full budget.
            cnt_d = expire ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ttt_move_ctrl.sv
// rtl/ttt_move_ctrl.sv - tic-tac-toe turn sequencer feeding the position decoder
// Optional feature macro: MOVE_TIMEOUT_EN (idle turn forfeit via ttt_turn_timer).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   new_game              synchronous clear to start-of-game, highest priority
//   move_valid/move_ready move request handshake, move_pos sampled on acceptance
//   win_detect            external checker reports a line for the last mover
//   pos_out/pos_en        committed cell and one-cycle decoder/board-write strobe
//   cur_player            player to move (0 = X, 1 = O)
//   move_reject           one-cycle pulse: illegal move dropped
//   turn_timeout          one-cycle pulse: turn forfeited (0 without MOVE_TIMEOUT_EN)
//   move_count            committed moves 0..9
//   game_over, winner     end-of-game flag and result code
module ttt_move_ctrl
    import ttt_pkg::*;
#(
    parameter int NUM_CELLS      = NUM_CELLS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic [POS_W-1:0] move_pos,
    output logic             move_ready,
    input  logic             win_detect,
    output logic [POS_W-1:0] pos_out,
    output logic             pos_en,
    output logic             cur_player,
    output logic             move_reject,
    output logic             turn_timeout,
    output logic [3:0]       move_count,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [POS_W-1:0] CELL_LIMIT = POS_W'(NUM_CELLS);
    localparam logic [3:0]       LAST_MOVE  = 4'(NUM_CELLS - 1);

    state_t               state_q, state_d;
    logic [NUM_CELLS-1:0] occ_q, occ_d;
    logic [POS_W-1:0]     pos_lat_q, pos_lat_d;
    logic [POS_W-1:0]     pos_out_q, pos_out_d;
    logic                 pos_en_q, pos_en_d;
    logic                 cur_player_q, cur_player_d;
    logic                 move_ready_q, move_ready_d;
    logic                 move_reject_q, move_reject_d;
    logic                 turn_timeout_q, turn_timeout_d;
    logic [3:0]           move_count_q, move_count_d;
    logic                 game_over_q, game_over_d;
    logic [1:0]           winner_q, winner_d;

    logic accept;
    logic tmr_expire;

    // A pending win report outranks a simultaneous move request.
    assign accept = (state_q == ST_IDLE) && move_valid && !win_detect && !new_game;

`ifdef MOVE_TIMEOUT_EN
    logic tmr_run;
    logic tmr_clear;

    assign tmr_run   = (state_q == ST_IDLE) && !new_game;
    assign tmr_clear = new_game || accept;

    ttt_turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_turn_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (tmr_run),
        .clear  (tmr_clear),
        .expire (tmr_expire)
    );
`else
    logic unused_timeout_cfg;

    assign tmr_expire         = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d        = state_q;
        occ_d          = occ_q;
        pos_lat_d      = pos_lat_q;
        pos_out_d      = pos_out_q;
        pos_en_d       = 1'b0;
        cur_player_d   = cur_player_q;
        move_ready_d   = move_ready_q;
        move_reject_d  = 1'b0;
        turn_timeout_d = 1'b0;
        move_count_d   = move_count_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;

        if (new_game) begin
            state_d      = ST_IDLE;
            occ_d        = '0;
            pos_lat_d    = '0;
            pos_out_d    = '0;
            cur_player_d = PLAYER_X;
            move_ready_d = 1'b1;
            move_count_d = 4'd0;
            game_over_d  = 1'b0;
            winner_d     = WIN_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_detect) begin
                        state_d      = ST_OVER;
                        move_ready_d = 1'b0;
                        game_over_d  = 1'b1;
                        winner_d     = winner_code(~cur_player_q);
                    end else if (accept) begin
                        state_d      = ST_CHECK;
                        pos_lat_d    = move_pos;
                        move_ready_d = 1'b0;
                    end else if (tmr_expire) begin
                        turn_timeout_d = 1'b1;
                        cur_player_d   = ~cur_player_q;
                    end
                end
                ST_CHECK: begin
                    // Range test first so the occupancy lookup is never out of bounds.
                    if ((pos_lat_q >= CELL_LIMIT) || occ_q[pos_lat_q]) begin
                        state_d       = ST_IDLE;
                        move_ready_d  = 1'b1;
                        move_reject_d = 1'b1;
                    end else begin
                        state_d   = ST_COMMIT;
                        pos_en_d  = 1'b1;
                        pos_out_d = pos_lat_q;
                    end
                end
                ST_COMMIT: begin
                    occ_d[pos_lat_q] = 1'b1;
                    move_count_d     = move_count_q + 4'd1;
                    cur_player_d     = ~cur_player_q;
                    if (move_count_q == LAST_MOVE) begin
                        state_d      = ST_OVER;
                        move_ready_d = 1'b0;
                        game_over_d  = 1'b1;
                        winner_d     = WIN_DRAW;
                    end else begin
                        state_d      = ST_IDLE;
                        move_ready_d = 1'b1;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d      = ST_IDLE;
                    move_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            occ_q          <= '0;
            pos_lat_q      <= '0;
            pos_out_q      <= '0;
            pos_en_q       <= 1'b0;
            cur_player_q   <= PLAYER_X;
            move_ready_q   <= 1'b1;
            move_reject_q  <= 1'b0;
            turn_timeout_q <= 1'b0;
            move_count_q   <= 4'd0;
            game_over_q    <= 1'b0;
            winner_q       <= WIN_NONE;
        end else begin
            state_q        <= state_d;
            occ_q          <= occ_d;
            pos_lat_q      <= pos_lat_d;
            pos_out_q      <= pos_out_d;
            pos_en_q       <= pos_en_d;
            cur_player_q   <= cur_player_d;
            move_ready_q   <= move_ready_d;
            move_reject_q  <= move_reject_d;
            turn_timeout_q <= turn_timeout_d;
            move_count_q   <= move_count_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
        end
    end

    assign move_ready   = move_ready_q;
    assign pos_out      = pos_out_q;
    assign pos_en       = pos_en_q;
    assign cur_player   = cur_player_q;
    assign move_reject  = move_reject_q;
    assign turn_timeout = turn_timeout_q;
    assign move_count   = move_count_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// tb/tb_ttt_move_ctrl.sv - directed self-checking bench for ttt_move_ctrl
module tb_ttt_move_ctrl;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       win_detect;
    logic [3:0] pos_out;
    logic       pos_en;
    logic       cur_player;
    logic       move_reject;
    logic       turn_timeout;
    logic [3:0] move_count;
    logic       game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    ttt_move_ctrl #(
        .NUM_CELLS      (9),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_game     (new_game),
        .move_valid   (move_valid),
        .move_pos     (move_pos),
        .move_ready   (move_ready),
        .win_detect   (win_detect),
        .pos_out      (pos_out),
        .pos_en       (pos_en),
        .cur_player   (cur_player),
        .move_reject  (move_reject),
        .turn_timeout (turn_timeout),
        .move_count   (move_count),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // Presents one move from IDLE and reports what appeared after the check edge.
    task automatic play(input logic [3:0] p, output logic saw_en,
                        output logic [3:0] saw_pos, output logic saw_rej);
        move_valid = 1'b1;
        move_pos   = p;
        tick();
        move_valid = 1'b0;
        tick();
        saw_en  = pos_en;
        saw_pos = pos_out;
        saw_rej = move_reject;
        if (saw_en) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL reset_move_ready: got %0b exp 1", move_ready); end
        checks++; if (pos_en !== 1'b0) begin errors++; $display("FAIL reset_pos_en: got %0b exp 0", pos_en); end
        checks++; if (pos_out !== 4'd0) begin errors++; $display("FAIL reset_pos_out: got %0d exp 0", pos_out); end
        checks++; if (cur_player !== 1'b0) begin errors++; $display("FAIL reset_cur_player: got %0b exp 0", cur_player); end
        checks++; if (move_count !== 4'd0) begin errors++; $display("FAIL reset_move_count: got %0d exp 0", move_count); end
        checks++; if ({game_over, winner} !== 3'b000) begin errors++; $display("FAIL reset_game_over_winner: got %b exp 000", {game_over, winner}); end
        checks++; if ({move_reject, turn_timeout} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b exp 00", {move_reject, turn_timeout}); end
    endtask

    task automatic test_first_move();
        move_valid = 1'b1;
        move_pos   = 4'd4;
        tick();
        move_valid = 1'b0;
        move_pos   = 4'd7;
        checks++; if ({move_ready, pos_en} !== 2'b00) begin errors++; $display("FAIL first_after_accept ready/en: got %b exp 00", {move_ready, pos_en}); end
        tick();
        checks++; if (pos_en !== 1'b1) begin errors++; $display("FAIL first_pos_en: got %0b exp 1", pos_en); end
        checks++; if (pos_out !== 4'd4) begin errors++; $display("FAIL first_pos_out: got %0d exp 4", pos_out); end
        checks++; if (move_ready !== 1'b0) begin errors++; $display("FAIL first_ready_in_commit: got %0b exp 0", move_ready); end
        tick();
        checks++; if (pos_en !== 1'b0) begin errors++; $display("FAIL first_pos_en_one_cycle: got %0b exp 0", pos_en); end
        checks++; if (cur_player !== 1'b1) begin errors++; $display("FAIL first_cur_player: got %0b exp 1", cur_player); end
        checks++; if (move_count !== 4'd1) begin errors++; $display("FAIL first_move_count: got %0d exp 1", move_count); end
        checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL first_ready_back: got %0b exp 1", move_ready); end
    endtask

    task automatic test_reject();
        logic       en;
        logic [3:0] pp;
        logic       rej;
        logic [3:0] bad [2] = '{4'd4, 4'd12};
        for (int i = 0; i < 2; i++) begin
            play(bad[i], en, pp, rej);
            checks++; if ({rej, en} !== 2'b10) begin errors++; $display("FAIL reject_%0d rej/en: got %b exp 10", bad[i], {rej, en}); end
            checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL reject_%0d ready: got %0b exp 1", bad[i], move_ready); end
            checks++; if ({cur_player, move_count} !== {1'b1, 4'd1}) begin errors++; $display("FAIL reject_%0d player/count: got %0b/%0d exp 1/1", bad[i], cur_player, move_count); end
            tick();
            checks++; if (move_reject !== 1'b0) begin errors++; $display("FAIL reject_%0d one_cycle: got %0b exp 0", bad[i], move_reject); end
        end
    endtask

    task automatic test_draw();
        logic       en;
        logic [3:0] pp;
        logic       rej;
        pulse_new_game();
        for (int i = 0; i < 9; i++) begin
            play(4'(i), en, pp, rej);
            checks++; if ({en, pp, rej} !== {1'b1, 4'(i), 1'b0}) begin errors++; $display("FAIL draw_move_%0d en/pos/rej: got %0b/%0d/%0b exp 1/%0d/0", i, en, pp, rej, i); end
        end
        checks++; if ({game_over, winner, move_ready} !== 4'b1110) begin errors++; $display("FAIL draw_over: got over/winner/ready %b exp 1110", {game_over, winner, move_ready}); end
        checks++; if ({move_count, cur_player} !== {4'd9, 1'b1}) begin errors++; $display("FAIL draw_count_player: got %0d/%0b exp 9/1", move_count, cur_player); end
        move_valid = 1'b1;
        move_pos   = 4'd0;
        en = 1'b0;
        rej = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            en  = en | pos_en;
            rej = rej | move_reject;
        end
        move_valid = 1'b0;
        checks++; if ({en, rej, move_count, game_over} !== {2'b00, 4'd9, 1'b1}) begin errors++; $display("FAIL draw_ignore_move: got en/rej/count/over %0b/%0b/%0d/%0b exp 0/0/9/1", en, rej, move_count, game_over); end
    endtask

    task automatic test_back_to_back_win();
        logic       en;
        logic [3:0] pp;
        logic       rej;
        logic [3:0] seq [3] = '{4'd0, 4'd8, 4'd2};
        pulse_new_game();
        for (int i = 0; i < 3; i++) begin
            play(seq[i], en, pp, rej);
            checks++; if ({en, pp} !== {1'b1, seq[i]}) begin errors++; $display("FAIL b2b_move_%0d en/pos: got %0b/%0d exp 1/%0d", i, en, pp, seq[i]); end
        end
        checks++; if ({move_count, cur_player} !== {4'd3, 1'b1}) begin errors++; $display("FAIL b2b_count_player: got %0d/%0b exp 3/1", move_count, cur_player); end
        win_detect = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd5;
        tick();
        win_detect = 1'b0;
        move_valid = 1'b0;
        checks++; if ({game_over, winner, move_ready} !== 4'b1010) begin errors++; $display("FAIL win_over: got over/winner/ready %b exp 1010", {game_over, winner, move_ready}); end
        win_detect = 1'b1;
        tick();
        tick();
        win_detect = 1'b0;
        checks++; if ({pos_en, move_count, winner} !== {1'b0, 4'd3, 2'b01}) begin errors++; $display("FAIL win_not_accepted: got en/count/winner %0b/%0d/%b exp 0/3/01", pos_en, move_count, winner); end
    endtask

    task automatic test_new_game_abort();
        logic       en;
        logic [3:0] pp;
        logic       rej;
        pulse_new_game();
        play(4'd0, en, pp, rej);
        move_valid = 1'b1;
        move_pos   = 4'd3;
        tick();
        move_valid = 1'b0;
        new_game   = 1'b1;
        tick();
        new_game   = 1'b0;
        checks++; if ({pos_en, move_ready} !== 2'b01) begin errors++; $display("FAIL abort_en/ready: got %b exp 01", {pos_en, move_ready}); end
        checks++; if ({move_count, cur_player, game_over, winner} !== 8'd0) begin errors++; $display("FAIL abort_cleared: got count/player/over/winner %0d/%0b/%0b/%b exp 0/0/0/00", move_count, cur_player, game_over, winner); end
        tick();
        checks++; if (pos_en !== 1'b0) begin errors++; $display("FAIL abort_no_late_en: got %0b exp 0", pos_en); end
        play(4'd0, en, pp, rej);
        checks++; if ({en, rej} !== 2'b10) begin errors++; $display("FAIL abort_occupancy_cleared: got en/rej %b exp 10", {en, rej}); end
    endtask

    task automatic test_async_reset();
        pulse_new_game();
        move_valid = 1'b1;
        move_pos   = 4'd6;
        tick();
        move_valid = 1'b0;
        tick();
        checks++; if (pos_en !== 1'b1) begin errors++; $display("FAIL async_pre_en: got %0b exp 1", pos_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({pos_en, move_ready, move_count} !== {2'b01, 4'd0}) begin errors++; $display("FAIL async_reset_outputs: got en/ready/count %0b/%0b/%0d exp 0/1/0", pos_en, move_ready, move_count); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if ({pos_en, cur_player, move_count} !== 6'd0) begin errors++; $display("FAIL async_after_release: got en/player/count %0b/%0b/%0d exp 0/0/0", pos_en, cur_player, move_count); end
    endtask

`ifdef MOVE_TIMEOUT_EN
    task automatic test_timeout();
        pulse_new_game();
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++; if (turn_timeout !== (k % 8 == 0)) begin errors++; $display("FAIL timeout_cycle_%0d pulse: got %0b exp %0b", k, turn_timeout, (k % 8 == 0)); end
            checks++; if (cur_player !== 1'((k / 8) % 2)) begin errors++; $display("FAIL timeout_cycle_%0d player: got %0b exp %0b", k, cur_player, 1'((k / 8) % 2)); end
        end
        checks++; if (move_count !== 4'd0) begin errors++; $display("FAIL timeout_count: got %0d exp 0", move_count); end
        pulse_new_game();
        repeat (7) tick();
        move_valid = 1'b1;
        move_pos   = 4'd2;
        tick();
        move_valid = 1'b0;
        checks++; if ({turn_timeout, cur_player, move_ready} !== 3'b000) begin errors++; $display("FAIL timeout_accept_wins: got to/player/ready %b exp 000", {turn_timeout, cur_player, move_ready}); end
        tick();
        tick();
        checks++; if ({cur_player, move_count} !== {1'b1, 4'd1}) begin errors++; $display("FAIL timeout_accept_commit: got %0b/%0d exp 1/1", cur_player, move_count); end
    endtask
`else
    task automatic test_no_timeout();
        logic seen;
        seen = 1'b0;
        pulse_new_game();
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | turn_timeout;
        end
        checks++; if ({seen, cur_player} !== 2'b00) begin errors++; $display("FAIL no_timeout: got pulse/player %b exp 00", {seen, cur_player}); end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        win_detect = 1'b0;
        test_reset();
        test_first_move();
        test_reject();
        test_draw();
        test_back_to_back_win();
        test_new_game_abort();
`ifdef MOVE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
